// File: rtl/block_move_ctrl_pkg.sv
// Shared definitions for the piece move/commit controller: field geometry,
// spawn pose, command encodings and controller states.
package block_move_ctrl_pkg;

  localparam int FIELD_W = 20;
  localparam int FIELD_H = 20;
  localparam int SPAWN_X = 8;
  localparam int SPAWN_Y = 0;

  typedef enum logic [1:0] {
    CMD_LEFT   = 2'd0,
    CMD_RIGHT  = 2'd1,
    CMD_ROTATE = 2'd2,
    CMD_DROP   = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CHECK       = 3'd1,
    ST_LOCK        = 3'd2,
    ST_SPAWN_CHECK = 3'd3,
    ST_OVER        = 3'd4
  } state_e;

endpackage

// File: rtl/block_move_ctrl_if.sv
// Command, collision-verdict and merge signals between the move controller
// (slave) and its surroundings (master: player input, checker, merger).
interface block_move_ctrl_if;
  import block_move_ctrl_pkg::*;

  logic       cmd_valid;
  cmd_e       cmd;
  logic       cmd_ready;
  logic       gravity_tick;
  logic       err;
  logic [5:0] cand_x;
  logic [5:0] cand_y;
  logic [1:0] cand_rot;
  logic [5:0] pos_x;
  logic [5:0] pos_y;
  logic [1:0] pos_rot;
  logic       lock_valid;
  logic       lock_ack;
  logic       new_piece;
  logic       game_over;

  modport master (
    output cmd_valid, cmd, gravity_tick, err, lock_ack,
    input  cmd_ready, cand_x, cand_y, cand_rot, pos_x, pos_y, pos_rot,
           lock_valid, new_piece, game_over
  );

  modport slave (
    input  cmd_valid, cmd, gravity_tick, err, lock_ack,
    output cmd_ready, cand_x, cand_y, cand_rot, pos_x, pos_y, pos_rot,
           lock_valid, new_piece, game_over
  );

endinterface

// File: rtl/block_move_ctrl_check_timer.sv
// Loadable down-counter timing the collision checker latency; done is high
// whenever the count has reached zero.
module block_move_ctrl_check_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/block_move_ctrl.sv
// Move/commit controller: builds candidate poses from commands and gravity,
// commits or reverts on the checker verdict, and runs lock/respawn/game-over.
//
// state          | meaning
// ST_IDLE        | pose settled; accept gravity (priority) or a command
// ST_CHECK       | candidate on the bus, waiting CHECK_LAT cycles for err
// ST_LOCK        | failed drop; lock_valid high until the merge is acked
// ST_SPAWN_CHECK | spawn pose on the bus, waiting for err
// ST_OVER        | spawn collided; frozen until reset
module block_move_ctrl #(
  parameter int FIELD_W   = block_move_ctrl_pkg::FIELD_W,
  parameter int FIELD_H   = block_move_ctrl_pkg::FIELD_H,
  parameter int SPAWN_X   = block_move_ctrl_pkg::SPAWN_X,
  parameter int SPAWN_Y   = block_move_ctrl_pkg::SPAWN_Y,
  parameter int CHECK_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  block_move_ctrl_if.slave bus
);
  import block_move_ctrl_pkg::*;

  localparam int              TMR_W    = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CHECK_LAT - 1);
  localparam logic [5:0]       SPX      = 6'(SPAWN_X);
  localparam logic [5:0]       SPY      = 6'(SPAWN_Y);

  if (SPAWN_X < 0 || SPAWN_X >= FIELD_W || SPAWN_Y < 0 || SPAWN_Y >= FIELD_H ||
      CHECK_LAT < 1) begin : g_bad_cfg
    $error("block_move_ctrl: spawn pose outside the field or CHECK_LAT < 1");
  end

  state_e     state;
  logic       gravity_pend;
  logic       lock_on_err;
  logic [5:0] cand_x, cand_y, pos_x, pos_y;
  logic [1:0] cand_rot, pos_rot;
  logic       lock_valid, new_piece, game_over;
  logic       grav_go, cmd_go, start_check, tmr_done;

  // Gravity outranks the player; cmd_ready reflects that in the same cycle.
  assign grav_go       = (state == ST_IDLE) && (gravity_pend || bus.gravity_tick);
  assign bus.cmd_ready = rst_n && (state == ST_IDLE) && !gravity_pend && !bus.gravity_tick;
  assign cmd_go        = bus.cmd_valid && bus.cmd_ready;
  assign start_check   = grav_go || cmd_go || ((state == ST_LOCK) && bus.lock_ack);

  block_move_ctrl_check_timer #(.CW(TMR_W)) u_check_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_check),
    .load_val (TMR_LOAD),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cand_x       <= SPX;
      cand_y       <= SPY;
      cand_rot     <= 2'd0;
      pos_x        <= SPX;
      pos_y        <= SPY;
      pos_rot      <= 2'd0;
      lock_on_err  <= 1'b0;
      lock_valid   <= 1'b0;
      new_piece    <= 1'b0;
      game_over    <= 1'b0;
      gravity_pend <= 1'b0;
    end else begin
      new_piece <= 1'b0;
      if (bus.gravity_tick && (state != ST_IDLE) && (state != ST_OVER)) begin
        gravity_pend <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          // cand equals pos here, so it is safe to build from pos.
          if (grav_go) begin
            cand_y       <= pos_y + 6'd1;
            lock_on_err  <= 1'b1;
            gravity_pend <= 1'b0;
            state        <= ST_CHECK;
          end else if (cmd_go) begin
            lock_on_err <= (bus.cmd == CMD_DROP);
            unique case (bus.cmd)
              CMD_LEFT:   cand_x   <= pos_x - 6'd1;
              CMD_RIGHT:  cand_x   <= pos_x + 6'd1;
              CMD_ROTATE: cand_rot <= pos_rot + 2'd1;
              CMD_DROP:   cand_y   <= pos_y + 6'd1;
            endcase
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (tmr_done) begin
            if (!bus.err) begin
              pos_x   <= cand_x;
              pos_y   <= cand_y;
              pos_rot <= cand_rot;
              state   <= ST_IDLE;
            end else begin
              cand_x   <= pos_x;
              cand_y   <= pos_y;
              cand_rot <= pos_rot;
              if (lock_on_err) begin
                lock_valid <= 1'b1;
                state      <= ST_LOCK;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_LOCK: begin
          if (bus.lock_ack) begin
            lock_valid <= 1'b0;
            cand_x     <= SPX;
            cand_y     <= SPY;
            cand_rot   <= 2'd0;
            state      <= ST_SPAWN_CHECK;
          end
        end
        ST_SPAWN_CHECK: begin
          if (tmr_done) begin
            if (!bus.err) begin
              pos_x     <= cand_x;
              pos_y     <= cand_y;
              pos_rot   <= cand_rot;
              new_piece <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              game_over <= 1'b1;
              state     <= ST_OVER;
            end
          end
        end
        ST_OVER: state <= ST_OVER;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cand_x     = cand_x;
  assign bus.cand_y     = cand_y;
  assign bus.cand_rot   = cand_rot;
  assign bus.pos_x      = pos_x;
  assign bus.pos_y      = pos_y;
  assign bus.pos_rot    = pos_rot;
  assign bus.lock_valid = lock_valid;
  assign bus.new_piece  = new_piece;
  assign bus.game_over  = game_over;

endmodule

// File: tb/tb_block_move_ctrl.sv
// Bench for block_move_ctrl: CHECK_LAT=1 and CHECK_LAT=3 instances share the
// stimulus; sel chooses which one the checks observe.
module tb_block_move_ctrl;
  import block_move_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic cmd_valid, gravity_tick, err, lock_ack;
  cmd_e cmd;
  bit   sel;

  block_move_ctrl_if bus1 ();
  block_move_ctrl_if bus3 ();

  assign bus1.cmd_valid    = cmd_valid;
  assign bus1.cmd          = cmd;
  assign bus1.gravity_tick = gravity_tick;
  assign bus1.err          = err;
  assign bus1.lock_ack     = lock_ack;
  assign bus3.cmd_valid    = cmd_valid;
  assign bus3.cmd          = cmd;
  assign bus3.gravity_tick = gravity_tick;
  assign bus3.err          = err;
  assign bus3.lock_ack     = lock_ack;

  block_move_ctrl #(.CHECK_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  block_move_ctrl #(.CHECK_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  logic [13:0] o_cand, o_pos;
  logic        o_ready, o_lock, o_new, o_go;
  assign o_cand  = sel ? {bus3.cand_x, bus3.cand_y, bus3.cand_rot}
                       : {bus1.cand_x, bus1.cand_y, bus1.cand_rot};
  assign o_pos   = sel ? {bus3.pos_x, bus3.pos_y, bus3.pos_rot}
                       : {bus1.pos_x, bus1.pos_y, bus1.pos_rot};
  assign o_ready = sel ? bus3.cmd_ready  : bus1.cmd_ready;
  assign o_lock  = sel ? bus3.lock_valid : bus1.lock_valid;
  assign o_new   = sel ? bus3.new_piece  : bus1.new_piece;
  assign o_go    = sel ? bus3.game_over  : bus1.game_over;

  typedef struct {
    bit          grav;
    cmd_e        c;
    bit          e;
    logic [13:0] cand;
    logic [13:0] pos;
  } vec_t;

  typedef struct {
    logic [13:0] pos;
    bit          lock;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [13:0] pose(input int x, input int y, input int r);
    return {6'(x), 6'(y), 2'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the controller", name);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (o_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout_fail({name, " ready"});
  endtask

  // One gravity step or command; expectations queue on drive, compare on verdict.
  task automatic run_move(input string name, input bit grav, input cmd_e c, input bit e,
                          input logic [13:0] exp_cand, input logic [13:0] exp_pos,
                          input bit exp_lock);
    exp_t x;
    int   n;
    wait_ready(name);
    err = e;
    if (grav) gravity_tick = 1'b1;
    else begin
      cmd_valid = 1'b1;
      cmd       = c;
    end
    x.pos  = exp_pos;
    x.lock = exp_lock;
    sb.push_back(x);
    @(negedge clk);
    gravity_tick = 1'b0;
    cmd_valid    = 1'b0;
    chk({name, " cand"}, 32'(o_cand), 32'(exp_cand));
    n = 0;
    while (o_ready !== 1'b1 && o_lock !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout_fail({name, " verdict"});
    x = sb.pop_front();
    chk({name, " pos"}, 32'(o_pos), 32'(x.pos));
    chk({name, " lock"}, 32'(o_lock), 32'(x.lock));
    chk({name, " cand_after"}, 32'(o_cand), 32'(x.pos));
  endtask

  vec_t vecs[10];
  int   mx, my, mr;
  int   np;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst_n = 1'b0;
    cmd_valid = 1'b0; cmd = CMD_LEFT; gravity_tick = 1'b0; err = 1'b0; lock_ack = 1'b0;

    vecs[0] = '{1'b0, CMD_LEFT,   1'b0, pose(7, 0, 0), pose(7, 0, 0)};
    vecs[1] = '{1'b0, CMD_RIGHT,  1'b0, pose(8, 0, 0), pose(8, 0, 0)};
    vecs[2] = '{1'b0, CMD_ROTATE, 1'b0, pose(8, 0, 1), pose(8, 0, 1)};
    vecs[3] = '{1'b0, CMD_ROTATE, 1'b1, pose(8, 0, 2), pose(8, 0, 1)};
    vecs[4] = '{1'b0, CMD_DROP,   1'b0, pose(8, 1, 1), pose(8, 1, 1)};
    vecs[5] = '{1'b1, CMD_LEFT,   1'b0, pose(8, 2, 1), pose(8, 2, 1)};
    vecs[6] = '{1'b0, CMD_RIGHT,  1'b1, pose(9, 2, 1), pose(8, 2, 1)};
    vecs[7] = '{1'b0, CMD_ROTATE, 1'b0, pose(8, 2, 2), pose(8, 2, 2)};
    vecs[8] = '{1'b0, CMD_ROTATE, 1'b0, pose(8, 2, 3), pose(8, 2, 3)};
    vecs[9] = '{1'b0, CMD_ROTATE, 1'b0, pose(8, 2, 0), pose(8, 2, 0)};

    // Reset values while rst_n is held low
    #12;
    chk("rst ready", 32'(o_ready), 32'd0);
    chk("rst pos", 32'(o_pos), 32'(pose(8, 0, 0)));
    chk("rst cand", 32'(o_cand), 32'(pose(8, 0, 0)));
    chk("rst flags", 32'({o_lock, o_new, o_go}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle ready", 32'(o_ready), 32'd1);

    for (int i = 0; i < 10; i++)
      run_move($sformatf("vec%0d", i), vecs[i].grav, vecs[i].c, vecs[i].e,
               vecs[i].cand, vecs[i].pos, 1'b0);
    mx = 8; my = 2; mr = 0;

    for (int i = 0; i < 8; i++) begin
      run_move("left_walk", 1'b0, CMD_LEFT, 1'b0, pose(mx - 1, my, mr), pose(mx - 1, my, mr), 1'b0);
      mx--;
    end
    run_move("left_oob", 1'b0, CMD_LEFT, 1'b1, pose(-1, 2, 0), pose(0, 2, 0), 1'b0);
    while (my < 18) begin
      run_move("drop_walk", 1'b0, CMD_DROP, 1'b0, pose(mx, my + 1, mr), pose(mx, my + 1, mr), 1'b0);
      my++;
    end

    // Failed gravity at the floor locks; lock_valid holds until the ack
    run_move("grav_lock", 1'b1, CMD_LEFT, 1'b1, pose(0, 19, 0), pose(0, 18, 0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_hold", 32'({o_lock, o_ready}), 32'b10);
    end
    err = 1'b0;
    lock_ack = 1'b1;
    @(negedge clk);
    lock_ack = 1'b0;
    chk("lock_drop", 32'(o_lock), 32'd0);
    chk("spawn_cand", 32'(o_cand), 32'(pose(8, 0, 0)));
    np = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      np += int'(o_new);
    end
    chk("new_piece_pulses", 32'(np), 32'd1);
    chk("spawn_pos", 32'(o_pos), 32'(pose(8, 0, 0)));
    chk("spawn_ready", 32'(o_ready), 32'd1);

    // Gravity and a command in the same IDLE cycle
    err = 1'b0;
    gravity_tick = 1'b1;
    cmd_valid = 1'b1;
    cmd = CMD_RIGHT;
    #1;
    chk("grav_prio_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    gravity_tick = 1'b0;
    chk("grav_prio_cand", 32'(o_cand), 32'(pose(8, 1, 0)));
    @(negedge clk);
    chk("grav_prio_pos", 32'(o_pos), 32'(pose(8, 1, 0)));
    chk("grav_prio_ready2", 32'(o_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("late_cmd_cand", 32'(o_cand), 32'(pose(9, 1, 0)));
    @(negedge clk);
    chk("late_cmd_pos", 32'(o_pos), 32'(pose(9, 1, 0)));

    // Failed soft drop locks; spawn collides -> game over
    run_move("drop_lock", 1'b0, CMD_DROP, 1'b1, pose(9, 2, 0), pose(9, 1, 0), 1'b1);
    lock_ack = 1'b1;
    @(negedge clk);
    lock_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("game_over", 32'(o_go), 32'd1);
    cmd_valid = 1'b1;
    cmd = CMD_LEFT;
    for (int i = 0; i < 6; i++) begin
      gravity_tick = (i % 2 == 0);
      @(negedge clk);
      chk("over_ready", 32'(o_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    gravity_tick = 1'b0;
    chk("over_sticky", 32'({o_go, o_lock, o_new}), 32'b100);
    chk("over_pos", 32'(o_pos), 32'(pose(9, 1, 0)));
    rst_n = 1'b0;
    #1;
    chk("over_reset", 32'({o_go, o_pos}), 32'({1'b0, pose(8, 0, 0)}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // CHECK_LAT=3 instance from here on
    sel = 1'b1;
    err = 1'b0;
    for (int r = 1; r < 4; r++)
      run_move("rot_lat3", 1'b0, CMD_ROTATE, 1'b0, pose(8, 0, r), pose(8, 0, r), 1'b0);

    wait_ready("rot_wrap");
    cmd_valid = 1'b1;
    cmd = CMD_ROTATE;
    err = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rot_wrap_cand1", 32'(o_cand), 32'(pose(8, 0, 0)));
    err = 1'b0;
    @(negedge clk);
    chk("rot_wrap_cand2", 32'(o_cand), 32'(pose(8, 0, 0)));
    err = 1'b1;
    @(negedge clk);
    chk("rot_wrap_cand3", 32'(o_cand), 32'(pose(8, 0, 0)));
    chk("rot_wrap_hold", 32'(o_pos), 32'(pose(8, 0, 3)));
    err = 1'b0;
    @(negedge clk);
    chk("rot_wrap_pos", 32'(o_pos), 32'(pose(8, 0, 0)));
    chk("rot_wrap_ready", 32'(o_ready), 32'd1);

    // Three ticks during CHECK merge into one extra gravity move
    cmd_valid = 1'b1;
    cmd = CMD_LEFT;
    @(negedge clk);
    cmd_valid = 1'b0;
    gravity_tick = 1'b1;
    repeat (3) @(negedge clk);
    gravity_tick = 1'b0;
    chk("pend_left_pos", 32'(o_pos), 32'(pose(7, 0, 0)));
    chk("pend_ready", 32'(o_ready), 32'd0);
    wait_ready("pend_grav");
    chk("pend_grav_pos", 32'(o_pos), 32'(pose(7, 1, 0)));
    repeat (6) @(negedge clk);
    chk("pend_once", 32'({o_ready, o_pos}), 32'({1'b1, pose(7, 1, 0)}));

    // Asynchronous reset in the middle of CHECK
    cmd_valid = 1'b1;
    cmd = CMD_RIGHT;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("midchk_cand", 32'(o_cand), 32'(pose(8, 1, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midchk_rst_cand", 32'(o_cand), 32'(pose(8, 0, 0)));
    chk("midchk_rst_pos", 32'(o_pos), 32'(pose(8, 0, 0)));
    chk("midchk_rst_flags", 32'({o_ready, o_lock, o_new, o_go}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midchk_no_commit", 32'({o_ready, o_pos}), 32'({1'b1, pose(8, 0, 0)}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_move_ctrl.md
Name: block_move_ctrl

Overview:
- Sequential move/commit controller sitting directly upstream of the field collision checker.
- Turns player commands and gravity ticks into a candidate piece pose (x, y, rotation) for the block expander.
- Waits for the checker's err verdict on that pose, then commits it or reverts.
- A failed gravity drop locks the piece; the block then runs the merge handshake, respawns, and detects game over.

Parameters:
- FIELD_W, 20, field width in cells (FIELD_W*FIELD_H = 400 matches the field buses)
- FIELD_H, 20, field height in cells
- SPAWN_X, 8, spawn column (signed)
- SPAWN_Y, 0, spawn row (signed)
- CHECK_LAT, 1, cycles from candidate change to valid err (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  player command present
- cmd  in  2  0=LEFT, 1=RIGHT, 2=ROTATE, 3=DROP (soft drop, one row)
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- gravity_tick  in  1  single-cycle gravity pulse
- err  in  1  collision/out-of-bounds verdict for current candidate
- cand_x  out  6  signed candidate column, to block expander
- cand_y  out  6  signed candidate row
- cand_rot  out  2  candidate rotation
- pos_x  out  6  committed column
- pos_y  out  6  committed row
- pos_rot  out  2  committed rotation
- lock_valid  out  1  committed pose must be merged into background
- lock_ack  in  1  merge complete
- new_piece  out  1  one-cycle pulse at spawn commit
- game_over  out  1  sticky; spawn pose collided

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; pos and cand = (SPAWN_X, SPAWN_Y, 0); cmd_ready=0 during reset; lock_valid=0, new_piece=0, game_over=0; gravity_pend=0.
- States: IDLE, CHECK, LOCK, SPAWN_CHECK, OVER.
- IDLE:
  - cmd_ready = !gravity_pend && !gravity_tick.
  - Gravity (tick or pend) has priority: cand_y=pos_y+1; go to CHECK with kind=GRAV; clear pend.
  - Otherwise, on a handshake, build the candidate:
    - LEFT: x-1
    - RIGHT: x+1
    - ROTATE: rot+1 mod 4 (3 wraps to 0)
    - DROP: y+1
  - Then go to CHECK with kind=CMD.
- gravity_tick outside IDLE sets gravity_pend; multiple ticks merge into one pend; pend is never lost.
- CHECK:
  - A counter loads CHECK_LAT-1 and counts down; err is sampled when the counter reaches 0, i.e. exactly CHECK_LAT cycles after the candidate registered.
  - err=0: pos<=cand; go to IDLE.
  - err=1: cand<=pos (revert). If kind=GRAV, or kind=CMD with cmd DROP, go to LOCK; else go to IDLE.
  - Candidate outputs are stable for the entire CHECK window.
- LOCK:
  - lock_valid=1; cand held equal to pos; wait for lock_ack (may arrive in the first LOCK cycle).
  - On ack: lock_valid drops next cycle; cand<=(SPAWN_X, SPAWN_Y, 0); go to SPAWN_CHECK.
- SPAWN_CHECK:
  - Same CHECK_LAT timing as CHECK.
  - err=0: pos<=cand; new_piece=1 for one cycle; go to IDLE.
  - err=1: game_over<=1; go to OVER.
- OVER: terminal until reset; cmd_ready=0; ticks ignored; outputs frozen.
- Arithmetic: 6-bit two's complement, no saturation. Out-of-range values (e.g. x=-1, x=FIELD_W) are legitimate candidates; the checker flags them via err, and they are never committed.
- Reset mid-CHECK or mid-LOCK: immediate return to reset values; no partial commit.

Decomposition:
- Shared package holds:
  - cmd encodings (CMD_LEFT..CMD_DROP)
  - FSM state encodings
  - FIELD_W/FIELD_H, SPAWN_X/SPAWN_Y defaults
- One natural sub-module: check_timer (loadable down-counter with done flag), reused by CHECK and SPAWN_CHECK.

Test Plan:
- Reset, then cmd LEFT with err=0 at CHECK_LAT=1 -> cmd_ready drops; cand_x=7; two cycles after the handshake, pos_x=7; back in IDLE with cmd_ready=1.
- pos_x=0, cmd LEFT, err=1 -> cand_x=-1 (6'h3F) during CHECK; pos_x stays 0; cand reverts to 0; no lock_valid.
- Gravity tick with err=1 at pos_y=18 -> lock_valid rises and holds until lock_ack. Then cand=(8,0,0); with err=0, new_piece pulses once; pos=(8,0,0).
- gravity_tick and cmd_valid in the same IDLE cycle -> gravity serviced first; cmd_ready=0 that cycle; cmd accepted after return to IDLE. Three ticks during CHECK -> exactly one extra gravity move.
- Spawn check with err=1 -> game_over=1 and sticky; cmd_ready=0; later ticks and commands cause no pos change until rst_n pulse.
- CHECK_LAT=3, ROTATE at rot=3 -> cand_rot=0, held stable 3 cycles; err toggling before the sample cycle is ignored; only the sample-cycle value decides. Assert rst_n low mid-CHECK -> all outputs at reset values asynchronously.
